if_fetch_buffer: RTL
====================

# if_fetch_buffer

Instruction-fetch stage that sits directly downstream of the PC register and upstream of decode. It issues the current PC to instruction memory over a valid/ready request channel and tracks up to DEPTH outstanding fetches. In-order responses are held in a small buffer and presented to decode with their PC over a valid/ready handshake. It drives `stall_n` back to the PC register so the PC advances only when a fetch is accepted, and it discards in-flight responses on any redirect.

## Interface
- `DEPTH`, 4: buffer entries and maximum outstanding fetches; power of 2, ≥2.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `flush` in 1: redirect (top ties to the PC register's `jump | flush`); kills buffered and in-flight fetches.
- `pc` in 32: current PC from the PC register.
- `stall_n` out 1: to the PC register; 1 exactly when a request handshake completes this cycle.
- `imem_req_valid` out 1, `imem_req_addr` out 32, `imem_req_ready` in 1: fetch request channel.
- `imem_rsp_valid` in 1, `imem_rsp_data` in 32: in-order responses, latency ≥1 cycle, no backpressure.
- `id_valid` out 1, `id_instr` out 32, `id_pc` out 32, `id_ready` in 1: decode channel.

## Operation
- Entry fields: `pc`, `instr`, `filled`. Pointers: `alloc`, `fill`, `head`, each log2(DEPTH)+1 bits (wrap bit). `count = alloc - head`. `drop` counter is log2(DEPTH)+1 bits.
- Request: `imem_req_valid = !flush && (count + drop < DEPTH)`; `imem_req_addr = pc`.
- On request handshake: `entry[alloc].pc <= pc`, `filled <= 0`, `alloc++`. `stall_n = imem_req_valid & imem_req_ready`.
- Response: if `drop != 0`, `drop--` and data is discarded. Otherwise `entry[fill].instr <= imem_rsp_data`, `filled <= 1`, `fill++`.
- Decode output: `id_valid = (count != 0) && entry[head].filled`; `id_instr` and `id_pc` come from `entry[head]`. Pop (`head++`) on `id_valid & id_ready`.
- Flush has priority over all other events in its cycle:
  - `alloc`, `fill` and `head` reset to 0; all `filled` bits clear.
  - No request is issued and no pop occurs.
  - `drop <= drop + (alloc - fill) - (imem_rsp_valid ? 1 : 0)`.
- Any response arriving when `drop == 0` and `fill == alloc` is a protocol violation. It is ignored and must not change state.
- Request, response and pop may all occur in one cycle; each pointer updates independently.

## Timing
- While `rst_n` is low: all pointers, `drop` and `filled` bits are 0. All outputs are 0, including `imem_req_valid` and `stall_n`.
- First request is issued in the first cycle after `rst_n` rises.
- Fetch-to-decode latency: memory latency + 1 cycle, because the response is registered before `id_valid` rises.
- Full: when `count + drop == DEPTH`, `imem_req_valid = 0` and `stall_n = 0`. A pop in the same cycle frees a slot only from the next cycle, since there is no same-cycle credit return.
- Pointer wrap: comparisons use the full wrap bit, so `count == DEPTH` is distinguished from `count == 0`.
- `id_valid` may drop only on pop or flush. `id_instr` and `id_pc` stay stable while `id_valid & !id_ready`.
- Reset asserted mid-operation clears everything asynchronously. Responses still in flight in memory are not dropped; the memory side must be reset together with this block.

## Configuration
- `IF_FETCH_BUF_BYPASS_EN` defined:
  - Condition: `count != 0`, `fill == head`, `drop == 0` and `imem_rsp_valid` in the same cycle.
  - Effect: `id_valid = 1` with `id_instr = imem_rsp_data` combinationally, giving a latency of memory latency + 0.
  - If `id_ready` is also high, the entry is popped and never marked filled; `fill` and `head` both advance.
- Not defined: no combinational path from `imem_rsp_*` to `id_*`; latency as in Timing.

## Test plan
- Reset, then `imem_req_ready = 1`, memory latency 1, `id_ready = 1` → requests go to 0x0, 0x4, 0x8, … `id_pc` matches each, first `id_valid` two cycles after the first request (one with bypass).
- Hold `id_ready = 0`, DEPTH=4 → exactly 4 requests are accepted, then `imem_req_valid = 0` and `stall_n = 0`. Releasing `id_ready` pops PCs 0x0..0xC in order.
- 3 outstanding fetches, `flush` pulsed for one cycle with no response that cycle → `drop = 3`. The next 3 responses are discarded; the first instruction delivered to decode is for the PC issued after the flush.
- `flush` in the same cycle as a response, with 2 outstanding → `drop = 1`, and no request is issued in the flush cycle.
- `imem_req_ready` toggles 1,0,1,0 → `stall_n` mirrors the handshake exactly, and the PC sequence has no gaps or duplicates.
- Assert `rst_n = 0` asynchronously with 2 buffered entries → `id_valid`, `imem_req_valid` and `stall_n` go to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/if_fetch_buffer.sv
// rtl/if_fetch_buffer.sv - instruction fetch buffer with outstanding-request tracking (option: IF_FETCH_BUF_BYPASS_EN)
module if_fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] pc,
    output logic        stall_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    alloc_q, fill_q, head_q, drop_q;
    logic [DEPTH-1:0] filled_q;
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];

    logic [PW-1:0] count, inflight;
    logic [PW:0]   occupancy;
    logic [AW-1:0] alloc_idx, fill_idx, head_idx;
    logic          req_valid_int, req_fire;
    logic          rsp_drop, rsp_fill;
    logic          bypass, id_valid_int, pop;

    assign alloc_idx = alloc_q[AW-1:0];
    assign fill_idx  = fill_q[AW-1:0];
    assign head_idx  = head_q[AW-1:0];

    // Wrap-bit pointers: count == DEPTH and count == 0 are distinct values.
    assign count     = alloc_q - head_q;
    assign inflight  = alloc_q - fill_q;
    assign occupancy = {1'b0, count} + {1'b0, drop_q};

    // A slot is only re-offered once both the buffer and the drop backlog leave room.
    assign req_valid_int  = rst_n && !flush && (occupancy < (PW+1)'(DEPTH));
    assign req_fire       = req_valid_int && imem_req_ready;
    assign imem_req_valid = req_valid_int;
    assign stall_n        = req_fire;
    assign imem_req_addr  = rst_n ? pc : 32'h0;

    // A response with nothing outstanding and nothing to drop is ignored.
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_fill = imem_rsp_valid && (drop_q == '0) && (fill_q != alloc_q);

`ifdef IF_FETCH_BUF_BYPASS_EN
    assign bypass       = rsp_fill && (count != '0) && (fill_q == head_q);
    assign id_valid_int = rst_n && !flush && (count != '0) && (filled_q[head_idx] || bypass);
    assign id_instr     = !rst_n ? 32'h0 : (bypass ? imem_rsp_data : instr_q[head_idx]);
`else
    assign bypass       = 1'b0;
    assign id_valid_int = rst_n && !flush && (count != '0) && filled_q[head_idx];
    assign id_instr     = rst_n ? instr_q[head_idx] : 32'h0;
`endif

    assign id_valid = id_valid_int;
    assign id_pc    = rst_n ? pc_q[head_idx] : 32'h0;
    assign pop      = id_valid_int && id_ready;

    // Pointer, drop-counter and filled-bit bookkeeping; flush overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_q  <= '0;
            fill_q   <= '0;
            head_q   <= '0;
            drop_q   <= '0;
            filled_q <= '0;
        end else if (flush) begin
            alloc_q  <= '0;
            fill_q   <= '0;
            head_q   <= '0;
            filled_q <= '0;
            drop_q   <= drop_q + inflight - PW'(rsp_drop || rsp_fill);
        end else begin
            if (req_fire) begin
                alloc_q             <= alloc_q + 1'b1;
                filled_q[alloc_idx] <= 1'b0;
            end
            if (rsp_fill) begin
                fill_q <= fill_q + 1'b1;
                if (!(bypass && pop)) begin
                    filled_q[fill_idx] <= 1'b1;
                end
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            if (rsp_drop) begin
                drop_q <= drop_q - 1'b1;
            end
        end
    end

    // Entry payload storage; validity is tracked by the filled bits and pointers.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_q[alloc_idx] <= pc;
        end
        if (rsp_fill && !flush) begin
            instr_q[fill_idx] <= imem_rsp_data;
        end
    end

endmodule
